// File: rtl/pin_tx_pkg.sv
// Shared constants, one-hot state encoding and helpers for the PIN transmitter.
package pin_tx_pkg;

  localparam int unsigned DIGIT_W         = 4;
  localparam int unsigned PIN_LEN         = 4;

  localparam int unsigned GAP_DEF         = 2;
  localparam int unsigned TIMEOUT_DEF     = 16;
  localparam int unsigned HOLD_DEF        = 8;
  localparam int unsigned MAX_FAIL_DEF    = 3;
  localparam int unsigned LOCK_CYCLES_DEF = 64;

  typedef enum logic [8:0] {
    StIdle      = 9'b0_0000_0001,
    StCaptura   = 9'b0_0000_0010,
    StSolicitar = 9'b0_0000_0100,
    StSetup     = 9'b0_0000_1000,
    StStrobe    = 9'b0_0001_0000,
    StGap       = 9'b0_0010_0000,
    StEspera    = 9'b0_0100_0000,
    StMostrar   = 9'b0_1000_0000,
    StBloqueo   = 9'b1_0000_0000
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pin_transmitter_cycle_timer.sv
// Loadable down-counter; done is high during the last cycle of a loaded interval.
module cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/pin_transmitter.sv
// Keypad-side PIN sender: captures four keys, paces them to the access controller,
// shows the verdict and locks out after repeated failures.
module pin_transmitter
  import pin_tx_pkg::*;
#(
  parameter int unsigned GAP         = GAP_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned HOLD        = HOLD_DEF,
  parameter int unsigned MAX_FAIL    = MAX_FAIL_DEF,
  parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               KEY_VALID,
  input  logic [DIGIT_W-1:0] KEY_CODE,
  input  logic               KEY_CLEAR,
  input  logic               ACCESO_ACEPTADO,
  input  logic               ACCESO_DENEGADO,
  output logic               SOLICITUD_ACCESO,
  output logic [DIGIT_W-1:0] DIGITO,
  output logic               DIGITO_STB,
  output logic               LED_OK,
  output logic               LED_ERROR,
  output logic               BLOQUEADO,
  output logic               BUSY
);

  localparam int unsigned TW = $clog2(max_u(max_u(GAP, TIMEOUT), max_u(HOLD, LOCK_CYCLES)) + 1);
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned CW = $clog2(PIN_LEN);

  state_e                            state_q, state_d;
  logic [PIN_LEN-1:0][DIGIT_W-1:0]   pin_q, pin_d;
  logic [CW-1:0]                     cnt_q, cnt_d, idx_q, idx_d;
  logic                              full_q, full_d;
  logic [FW-1:0]                     fail_q, fail_d;
  logic                              sol_q, sol_d, stb_q, stb_d, ok_q, ok_d, err_q, err_d;
  logic                              blq_q, blq_d, busy_q, busy_d;
  logic [DIGIT_W-1:0]                dig_q, dig_d;
  logic                              tmr_load, tmr_done;
  logic [TW-1:0]                     tmr_value;

  cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk   (CLK),
    .rst   (RESET),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    pin_d     = pin_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    idx_d     = idx_q;
    fail_d    = fail_q;
    ok_d      = ok_q;
    err_d     = err_q;
    tmr_load  = 1'b0;
    tmr_value = '0;

    unique case (state_q)
      StIdle, StCaptura: begin
        if (KEY_CLEAR) begin
          pin_d   = '0;
          cnt_d   = '0;
          full_d  = 1'b0;
          state_d = StIdle;
        end else if (KEY_VALID && !full_q) begin
          pin_d[cnt_q] = KEY_CODE;
          cnt_d        = cnt_q + CW'(1);
          if (cnt_q == CW'(PIN_LEN - 1)) begin
            full_d  = 1'b1;
            state_d = StSolicitar;
          end else begin
            state_d = StCaptura;
          end
        end
      end
      StSolicitar: begin
        idx_d   = '0;
        state_d = StSetup;
      end
      StSetup:  state_d = StStrobe;
      StStrobe: begin
        state_d   = StGap;
        tmr_load  = 1'b1;
        tmr_value = TW'(GAP);
      end
      StGap: begin
        if (tmr_done) begin
          if (idx_q == CW'(PIN_LEN - 1)) begin
            state_d   = StEspera;
            tmr_load  = 1'b1;
            tmr_value = TW'(TIMEOUT);
          end else begin
            idx_d   = idx_q + CW'(1);
            state_d = StSetup;
          end
        end
      end
      StEspera: begin
        // A grant in the final timeout cycle still counts; denial wins over a grant.
        if (ACCESO_DENEGADO || (!ACCESO_ACEPTADO && tmr_done)) begin
          err_d     = 1'b1;
          fail_d    = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);
          state_d   = StMostrar;
          tmr_load  = 1'b1;
          tmr_value = TW'(HOLD);
        end else if (ACCESO_ACEPTADO) begin
          ok_d      = 1'b1;
          fail_d    = '0;
          state_d   = StMostrar;
          tmr_load  = 1'b1;
          tmr_value = TW'(HOLD);
        end
      end
      StMostrar: begin
        if (tmr_done) begin
          ok_d   = 1'b0;
          err_d  = 1'b0;
          pin_d  = '0;
          cnt_d  = '0;
          full_d = 1'b0;
          if (fail_q == FW'(MAX_FAIL)) begin
            state_d   = StBloqueo;
            tmr_load  = 1'b1;
            tmr_value = TW'(LOCK_CYCLES);
          end else begin
            state_d = StIdle;
          end
        end
      end
      StBloqueo: begin
        if (tmr_done) begin
          fail_d  = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they come straight from flops.
  always_comb begin
    sol_d  = (state_d == StSolicitar);
    stb_d  = (state_d == StStrobe);
    blq_d  = (state_d == StBloqueo);
    busy_d = !((state_d == StIdle) || (state_d == StCaptura));
    dig_d  = (state_d == StSetup) ? pin_q[idx_d] : dig_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      pin_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      idx_q   <= '0;
      fail_q  <= '0;
      sol_q   <= 1'b0;
      stb_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      blq_q   <= 1'b0;
      busy_q  <= 1'b0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      pin_q   <= pin_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      sol_q   <= sol_d;
      stb_q   <= stb_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      blq_q   <= blq_d;
      busy_q  <= busy_d;
      dig_q   <= dig_d;
    end
  end

  assign SOLICITUD_ACCESO = sol_q;
  assign DIGITO_STB       = stb_q;
  assign DIGITO           = dig_q;
  assign LED_OK           = ok_q;
  assign LED_ERROR        = err_q;
  assign BLOQUEADO        = blq_q;
  assign BUSY             = busy_q;

endmodule

// File: tb/tb_pin_transmitter.sv
// Scoreboard bench for pin_transmitter with default parameters.
module tb_pin_transmitter;

  localparam int GAP  = 2;
  localparam int HOLD = 8;
  localparam int LOCK = 64;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       KEY_VALID = 1'b0;
  logic [3:0] KEY_CODE = '0;
  logic       KEY_CLEAR = 1'b0;
  logic       ACCESO_ACEPTADO = 1'b0;
  logic       ACCESO_DENEGADO = 1'b0;
  logic       SOLICITUD_ACCESO, DIGITO_STB, LED_OK, LED_ERROR, BLOQUEADO, BUSY;
  logic [3:0] DIGITO;

  pin_transmitter dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .KEY_VALID        (KEY_VALID),
    .KEY_CODE         (KEY_CODE),
    .KEY_CLEAR        (KEY_CLEAR),
    .ACCESO_ACEPTADO  (ACCESO_ACEPTADO),
    .ACCESO_DENEGADO  (ACCESO_DENEGADO),
    .SOLICITUD_ACCESO (SOLICITUD_ACCESO),
    .DIGITO           (DIGITO),
    .DIGITO_STB       (DIGITO_STB),
    .LED_OK           (LED_OK),
    .LED_ERROR        (LED_ERROR),
    .BLOQUEADO        (BLOQUEADO),
    .BUSY             (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] digit;
    int         cyc;
  } stb_t;

  stb_t       stb_exp[$];
  int         sol_exp[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] prev_dig = '0;
  logic       prev_blq = 1'b0;
  int         blq_rise = -1;
  int         blq_fall = -1;

  always @(posedge CLK) cyc <= cyc + 1;

  // Strobe/request monitor: pops expected events as the DUT produces them.
  always @(negedge CLK) begin
    stb_t e;
    int   s;
    if (DIGITO_STB) begin
      checks++;
      if (stb_exp.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe cyc=%0d got digit=%0h required none", cyc, DIGITO);
      end else begin
        e = stb_exp.pop_front();
        if (DIGITO !== e.digit || cyc != e.cyc || prev_dig !== DIGITO || SOLICITUD_ACCESO) begin
          errors++;
          $display("FAIL strobe got digit=%0h cyc=%0d setup=%0h sol=%0b required digit=%0h cyc=%0d",
                   DIGITO, cyc, prev_dig, SOLICITUD_ACCESO, e.digit, e.cyc);
        end
      end
    end
    if (SOLICITUD_ACCESO) begin
      checks++;
      if (sol_exp.size() == 0) begin
        errors++;
        $display("FAIL unexpected_request cyc=%0d required none", cyc);
      end else begin
        s = sol_exp.pop_front();
        if (cyc != s) begin
          errors++;
          $display("FAIL request_cycle got %0d required %0d", cyc, s);
        end
      end
    end
    if (BLOQUEADO && !prev_blq) blq_rise = cyc;
    if (!BLOQUEADO && prev_blq) blq_fall = cyc;
    prev_blq = BLOQUEADO;
    prev_dig = DIGITO;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] code);
    @(posedge CLK); #1;
    KEY_VALID = 1'b1;
    KEY_CODE  = code;
    @(posedge CLK); #1;
    KEY_VALID = 1'b0;
  endtask

  task automatic send_pin(input logic [3:0] d0, d1, d2, d3, output int k);
    logic [3:0] d[4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) press(d[i]);
    k = cyc;
    sol_exp.push_back(k);
    for (int i = 0; i < 4; i++) stb_exp.push_back('{digit: d[i], cyc: k + 2 + i * (2 + GAP)});
  endtask

  // Drives a one-cycle verdict during the first ESPERA_RES cycle.
  task automatic verdict(input int k, input logic acc, input logic den);
    wait_cyc(k + 17);
    ACCESO_ACEPTADO = acc;
    ACCESO_DENEGADO = den;
    @(posedge CLK); #1;
    ACCESO_ACEPTADO = 1'b0;
    ACCESO_DENEGADO = 1'b0;
  endtask

  task automatic measure(input int from, input int to, output int ok_first, output int ok_cnt,
                         output int err_first, output int err_cnt);
    ok_first = -1; ok_cnt = 0; err_first = -1; err_cnt = 0;
    while (cyc < to) begin
      @(negedge CLK);
      if (cyc >= from && cyc < to) begin
        if (LED_OK) begin
          ok_cnt++;
          if (ok_first < 0) ok_first = cyc;
        end
        if (LED_ERROR) begin
          err_cnt++;
          if (err_first < 0) err_first = cyc;
        end
      end
    end
    #1;
  endtask

  task automatic check_led(input string name, input int got_first, input int got_cnt,
                           input int exp_first, input int exp_cnt);
    checks++;
    if (got_first != exp_first || got_cnt != exp_cnt) begin
      errors++;
      $display("FAIL %s got first=%0d count=%0d required first=%0d count=%0d",
               name, got_first, got_cnt, exp_first, exp_cnt);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (BUSY !== 1'b0 || stb_exp.size() != 0 || sol_exp.size() != 0) begin
      errors++;
      $display("FAIL %s got busy=%0b pending_strobes=%0d pending_req=%0d required 0/0/0",
               name, BUSY, stb_exp.size(), sol_exp.size());
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({SOLICITUD_ACCESO, DIGITO, DIGITO_STB, LED_OK, LED_ERROR, BLOQUEADO, BUSY} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 0", {SOLICITUD_ACCESO, DIGITO, DIGITO_STB,
               LED_OK, LED_ERROR, BLOQUEADO, BUSY});
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic test_accept();
    int k, of, oc, ef, ec;
    send_pin(4'h6, 4'h9, 4'h6, 4'h9, k);
    verdict(k, 1'b1, 1'b0);
    measure(k + 18, k + 30, of, oc, ef, ec);
    check_led("accept_led_ok", of, oc, k + 18, HOLD);
    check_led("accept_led_err", ef, ec, -1, 0);
    check_idle("accept_idle");
  endtask

  task automatic test_clear();
    int k, of, oc, ef, ec;
    press(4'h1);
    press(4'h2);
    @(posedge CLK); #1;
    KEY_CLEAR = 1'b1;
    @(posedge CLK); #1;
    KEY_CLEAR = 1'b0;
    wait_cyc(cyc + 5);
    check_idle("clear_idle");
    send_pin(4'h3, 4'h4, 4'h5, 4'h6, k);
    verdict(k, 1'b1, 1'b0);
    measure(k + 18, k + 30, of, oc, ef, ec);
    check_led("clear_led_ok", of, oc, k + 18, HOLD);
    check_idle("clear_done_idle");
  endtask

  task automatic test_timeout();
    int k, of, oc, ef, ec;
    send_pin(4'hA, 4'h0, 4'hF, 4'h5, k);
    measure(k + 17, k + 45, of, oc, ef, ec);
    check_led("timeout_led_err", ef, ec, k + 33, HOLD);
    check_led("timeout_led_ok", of, oc, -1, 0);
    check_idle("timeout_idle");
  endtask

  task automatic test_deny();
    int k, of, oc, ef, ec;
    send_pin(4'h1, 4'h1, 4'h2, 4'h2, k);
    verdict(k, 1'b0, 1'b1);
    measure(k + 18, k + 30, of, oc, ef, ec);
    check_led("deny_led_err", ef, ec, k + 18, HOLD);
    check_idle("deny_idle");
    checks++;
    if (blq_rise != -1) begin
      errors++;
      $display("FAIL early_lockout got rise=%0d required none", blq_rise);
    end
  endtask

  task automatic test_both_lockout();
    int k, of, oc, ef, ec;
    send_pin(4'hC, 4'hD, 4'hE, 4'h7, k);
    verdict(k, 1'b1, 1'b1);
    measure(k + 18, k + 30, of, oc, ef, ec);
    check_led("both_led_err", ef, ec, k + 18, HOLD);
    check_led("both_led_ok", of, oc, -1, 0);
    for (int i = 0; i < 4; i++) press(4'h8);
    checks++;
    if (BLOQUEADO !== 1'b1 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL lockout_flags got blq=%0b busy=%0b required 1/1", BLOQUEADO, BUSY);
    end
    wait_cyc(k + 95);
    checks++;
    if (blq_rise != k + 26 || blq_fall - blq_rise != LOCK) begin
      errors++;
      $display("FAIL lockout_window got rise=%0d len=%0d required rise=%0d len=%0d",
               blq_rise, blq_fall - blq_rise, k + 26, LOCK);
    end
    check_idle("lockout_idle");
    send_pin(4'h2, 4'h4, 4'h6, 4'h8, k);
    verdict(k, 1'b1, 1'b0);
    measure(k + 18, k + 30, of, oc, ef, ec);
    check_led("post_lock_led_ok", of, oc, k + 18, HOLD);
  endtask

  task automatic test_midreset();
    int k, of, oc, ef, ec;
    send_pin(4'hA, 4'hB, 4'hC, 4'hD, k);
    wait_cyc(k + 8);
    #3;
    RESET = 1'b1;
    #1;
    checks++;
    if ({SOLICITUD_ACCESO, DIGITO, DIGITO_STB, LED_OK, LED_ERROR, BLOQUEADO, BUSY} !== 10'b0) begin
      errors++;
      $display("FAIL midreset_outputs got %b required 0", {SOLICITUD_ACCESO, DIGITO, DIGITO_STB,
               LED_OK, LED_ERROR, BLOQUEADO, BUSY});
    end
    void'(stb_exp.pop_back());
    void'(stb_exp.pop_back());
    @(posedge CLK); #1;
    RESET = 1'b0;
    wait_cyc(cyc + 30);
    check_idle("midreset_idle");
    send_pin(4'h5, 4'h5, 4'h0, 4'h1, k);
    verdict(k, 1'b1, 1'b0);
    measure(k + 18, k + 30, of, oc, ef, ec);
    check_led("midreset_led_ok", of, oc, k + 18, HOLD);
    check_idle("final_idle");
  endtask

  initial begin
    test_reset();
    test_accept();
    test_clear();
    test_timeout();
    test_deny();
    test_both_lockout();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pin_transmitter.md
# pin_transmitter

Keypad-side front end for the access controller's PIN protocol. Collects four key presses into a buffer, then drives the controller's inputs `SOLICITUD_ACCESO`, `DIGITO` and `DIGITO_STB` as a paced sequence. It waits for `ACCESO_ACEPTADO` or `ACCESO_DENEGADO`, displays the result, and enforces a lockout after repeated failures. It sits between the keypad decoder and the access controller, on the initiator side of the access link.

## Interface
- `GAP`, 2: idle cycles after each digit strobe (≥1).
- `TIMEOUT`, 16: cycles to wait for a verdict before declaring denial (≥1).
- `HOLD`, 8: cycles the result LED stays lit (≥1).
- `MAX_FAIL`, 3: consecutive failures that trigger lockout (≥1).
- `LOCK_CYCLES`, 64: lockout duration (≥1).
- `CLK`  in  1  single clock; all state changes on the rising edge.
- `RESET`  in  1  asynchronous, active-high; clears all state immediately.
- `KEY_VALID`  in  1  one-cycle pulse; `KEY_CODE` is valid.
- `KEY_CODE`  in  4  key value, 0x0–0xF all accepted.
- `KEY_CLEAR`  in  1  one-cycle pulse; discard partial entry.
- `ACCESO_ACEPTADO`  in  1  verdict from the controller.
- `ACCESO_DENEGADO`  in  1  verdict from the controller.
- `SOLICITUD_ACCESO`  out  1  one-cycle access request.
- `DIGITO`  out  4  digit presented to the controller.
- `DIGITO_STB`  out  1  one-cycle digit strobe.
- `LED_OK`  out  1  access granted indication.
- `LED_ERROR`  out  1  denial or timeout indication.
- `BLOQUEADO`  out  1  lockout active.
- `BUSY`  out  1  key input is being ignored.

## Operation
- States (one-hot): IDLE, CAPTURA, SOLICITAR, SETUP, STROBE, GAP_ST, ESPERA_RES, MOSTRAR, BLOQUEO.
- Key capture:
  - In IDLE or CAPTURA, `KEY_VALID` stores `KEY_CODE` at buffer index `cnt` and increments `cnt` (2-bit count plus a full flag).
  - The first key moves IDLE→CAPTURA.
  - The 4th key moves to SOLICITAR.
- `KEY_CLEAR` in CAPTURA empties the buffer and returns to IDLE. If `KEY_CLEAR` and `KEY_VALID` arrive in the same cycle, clear wins.
- Keys and clears in any other state are ignored.
- SOLICITAR lasts 1 cycle, then goes to SETUP with digit index i=0.
- Per digit i:
  - SETUP (1 cycle): `DIGITO`=buf[i].
  - STROBE (1 cycle): `DIGITO_STB`=1.
  - GAP_ST (`GAP` cycles).
  - Then i+1 goes to SETUP; after i=3, go to ESPERA_RES.
  - `DIGITO` loads only on entering SETUP and holds otherwise.
- ESPERA_RES:
  - `ACCESO_ACEPTADO` alone → MOSTRAR with `LED_OK`=1; fail counter cleared.
  - `ACCESO_DENEGADO` (including when both are high) → MOSTRAR with `LED_ERROR`=1; fail counter +1.
  - No verdict by the `TIMEOUT`-th cycle in the state → treated as denial in that cycle.
  - Verdict inputs are ignored outside ESPERA_RES.
- MOSTRAR:
  - Lasts `HOLD` cycles, then LEDs clear and the buffer is emptied.
  - If fail counter == `MAX_FAIL` → BLOQUEO; else → IDLE.
- BLOQUEO: `BLOQUEADO`=1 for `LOCK_CYCLES` cycles, then fail counter cleared and state → IDLE.
- The fail counter saturates at `MAX_FAIL`.
- `BUSY`=1 in every state except IDLE and CAPTURA.

## Timing
- All outputs are registered (driven from flops, no combinational paths from inputs).
- Reset values: all outputs 0, state IDLE, buffer 0, all counters 0.
- `RESET` asserted mid-sequence aborts immediately. A partially sent PIN is never resumed.
- Reference cycle: the 4th key is sampled at edge k.
  - `SOLICITUD_ACCESO`=1 during cycle k+1.
  - Digit i strobes during cycle k+3+i·(2+`GAP`).
  - With `GAP`=2: strobes at k+3, k+7, k+11, k+15; ESPERA_RES entered at k+18.
- `DIGITO` is stable from its SETUP cycle until the next SETUP. It is therefore stable at least 1 cycle before and `GAP` cycles after its strobe.
- `SOLICITUD_ACCESO` and `DIGITO_STB` are never high in the same cycle.
- A verdict sampled at edge e sets its LED in cycle e+1. The LED stays high for exactly `HOLD` cycles.
- Counter widths are `$clog2(max+1)` of the governing parameter.

## Structure
- Package `pin_tx_pkg`: one-hot state constants, parameter defaults, `DIGIT_W`=4, `PIN_LEN`=4.
- One sub-module, `cycle_timer`:
  - Loadable down-counter with a `done` pulse.
  - Reused for the GAP, TIMEOUT, HOLD and LOCK_CYCLES intervals; only one interval is active at a time.

## Test plan
- Keys 6,9,6,9, then `ACCESO_ACEPTADO` at the first ESPERA_RES cycle → `SOLICITUD_ACCESO` at k+1; strobes at k+3/7/11/15 with `DIGITO`=6,9,6,9; `LED_OK` high 8 cycles; return to IDLE.
- Keys 1,2 then `KEY_CLEAR`; then 3,4,5,6 → only 3,4,5,6 transmitted, no request after the clear alone.
- PIN sent, no verdict → `LED_ERROR` after 16 cycles in ESPERA_RES; fail counter =1.
- Three consecutive denials → `BLOQUEADO` high 64 cycles; keys during lockout ignored; afterwards a new PIN is accepted.
- `RESET` pulsed between the 2nd and 3rd strobe → all outputs 0 asynchronously; no further strobes; IDLE.
- `ACCESO_ACEPTADO` and `ACCESO_DENEGADO` high in the same cycle → `LED_ERROR`=1, `LED_OK`=0.
